// File: rtl/axi4lite_pkg.sv
// Shared definitions for the AXI4-Lite master/slave pair and the request arbiter
// in front of the master: arbiter states, default widths and response codes.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } arb_state_e;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4lite_req_arbiter_if.sv
// Requester-side and master-side signals of the request arbiter. The slave modport
// is the arbiter's view; the master modport is the view of the surrounding system.
interface axi4lite_req_arbiter_if
    import axi4lite_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   busy;
    logic                   mst_start_write;
    logic                   mst_start_read;
    logic [ADDR_W-1:0]      mst_write_addr;
    logic [ADDR_W-1:0]      mst_read_addr;
    logic [DATA_W-1:0]      mst_wdata;
    logic [DATA_W-1:0]      mst_rdata;
    logic                   mst_done;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mst_rdata, mst_done,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mst_start_write, mst_start_read, mst_write_addr, mst_read_addr, mst_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mst_rdata, mst_done,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               mst_start_write, mst_start_read, mst_write_addr, mst_read_addr, mst_wdata
    );

endinterface

// File: rtl/rr_grant_picker.sv
// Combinational round-robin pick: first set req_valid bit at or above rr_ptr,
// wrapping at NREQ, returned as a one-hot grant plus its index.
module rr_grant_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    logic [NREQ-1:0]  grant_s;
    logic [IDX_W-1:0] idx_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic             hit_s;

    // Scan candidates in priority order; the first hit locks out the rest.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        cand_s  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s          = IDX_W'((int'(rr_ptr) + i) % NREQ);
            hit_s           = !found_s && req_valid[cand_s];
            grant_s[cand_s] = grant_s[cand_s] | hit_s;
            idx_s           = hit_s ? cand_s : idx_s;
            found_s         = found_s | hit_s;
        end
    end

    assign grant = grant_s;
    assign idx   = idx_s;
    assign any   = found_s;

endmodule

// File: rtl/axi4lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NREQ requesters.
// Optional WAIT watchdog with rsp_err reporting: define AXI4LITE_ARB_TIMEOUT_EN.
module axi4lite_req_arbiter
    import axi4lite_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    axi4lite_req_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  gnt_idx_r;
    logic [NREQ-1:0]   gnt_oh_r;
    logic              cmd_write_r;
    logic [NREQ-1:0]   req_ready_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;
    logic              busy_r;
    logic              mst_start_write_r;
    logic              mst_start_read_r;
    logic [ADDR_W-1:0] mst_addr_r;
    logic [DATA_W-1:0] mst_wdata_r;

    logic [NREQ-1:0]   pick_grant_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              pick_any_s;

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [TMO_W-1:0]  tmo_cnt_r;
`endif

    rr_grant_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr_r),
        .grant     (pick_grant_s),
        .idx       (pick_idx_s),
        .any       (pick_any_s)
    );

    // Arbiter FSM; every output is a register, pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= ST_IDLE;
            rr_ptr_r          <= '0;
            gnt_idx_r         <= '0;
            gnt_oh_r          <= '0;
            cmd_write_r       <= 1'b0;
            req_ready_r       <= '0;
            rsp_valid_r       <= '0;
            rsp_rdata_r       <= '0;
            rsp_err_r         <= 1'b0;
            busy_r            <= 1'b0;
            mst_start_write_r <= 1'b0;
            mst_start_read_r  <= 1'b0;
            mst_addr_r        <= '0;
            mst_wdata_r       <= '0;
`ifdef AXI4LITE_ARB_TIMEOUT_EN
            tmo_cnt_r         <= '0;
`endif
        end else begin
            req_ready_r       <= '0;
            rsp_valid_r       <= '0;
            mst_start_write_r <= 1'b0;
            mst_start_read_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        // Start pulse and address become visible together during ISSUE.
                        gnt_idx_r         <= pick_idx_s;
                        gnt_oh_r          <= pick_grant_s;
                        req_ready_r       <= pick_grant_s;
                        cmd_write_r       <= bus.req_write[pick_idx_s];
                        mst_start_write_r <= bus.req_write[pick_idx_s];
                        mst_start_read_r  <= !bus.req_write[pick_idx_s];
                        mst_addr_r        <= bus.req_addr[pick_idx_s*ADDR_W +: ADDR_W];
                        mst_wdata_r       <= bus.req_wdata[pick_idx_s*DATA_W +: DATA_W];
                        busy_r            <= 1'b1;
                        state_r           <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                    state_r   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mst_done) begin
                        rsp_valid_r <= gnt_oh_r;
                        rsp_rdata_r <= cmd_write_r ? {DATA_W{1'b0}} : bus.mst_rdata;
                        rsp_err_r   <= 1'b0;
                        state_r     <= ST_RESP;
                    end
`ifdef AXI4LITE_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_r <= gnt_oh_r;
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_RESP: begin
                    rr_ptr_r <= (gnt_idx_r == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : gnt_idx_r + IDX_W'(1);
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.rsp_valid       = rsp_valid_r;
    assign bus.rsp_rdata       = rsp_rdata_r;
    assign bus.rsp_err         = rsp_err_r;
    assign bus.busy            = busy_r;
    assign bus.mst_start_write = mst_start_write_r;
    assign bus.mst_start_read  = mst_start_read_r;
    assign bus.mst_write_addr  = mst_addr_r;
    assign bus.mst_read_addr   = mst_addr_r;
    assign bus.mst_wdata       = mst_wdata_r;

endmodule

// File: tb/tb_axi4lite_req_arbiter.sv
// Scoreboard bench for axi4lite_req_arbiter with a behavioural master/slave register model.
// Timeout checks are compiled in when AXI4LITE_ARB_TIMEOUT_EN is defined.
module tb_axi4lite_req_arbiter;

    typedef struct {
        int         r;
        bit         wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit         err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   last_lat = 0;
    int   lat = 0;
    bit   stall = 1'b0;

    exp_t grant_q[$];
    exp_t cmd_q[$];
    exp_t rsp_q[$];

    logic [7:0] regs [4];
    bit         pend;
    bit         pwr;
    logic [1:0] paddr;
    logic [7:0] pwd;
    int         cnt;

    axi4lite_req_arbiter_if #(.NREQ(2), .ADDR_W(2), .DATA_W(8)) bus ();

    axi4lite_req_arbiter #(
        .NREQ(2), .ADDR_W(2), .DATA_W(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input int r);
        logic [1:0] one;
        one = 2'b01;
        return one << r;
    endfunction

    function automatic void expect_txn(input int r, input bit wr, input logic [1:0] a,
                                       input logic [7:0] wd, input logic [7:0] rd, input bit err);
        exp_t e;
        e.r = r; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rd; e.err = err;
        grant_q.push_back(e);
        cmd_q.push_back(e);
        rsp_q.push_back(e);
    endfunction

    // Master/slave model: register file behind a done pulse 'lat' cycles after start.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mst_done  <= 1'b0;
            bus.mst_rdata <= 8'h00;
            pend <= 1'b0; pwr <= 1'b0; paddr <= 2'd0; pwd <= 8'h00; cnt <= 0;
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else begin
            bus.mst_done <= 1'b0;
            if ((bus.mst_start_write || bus.mst_start_read) && !stall) begin
                if (lat == 0) begin
                    bus.mst_done <= 1'b1;
                    if (bus.mst_start_write) begin
                        regs[bus.mst_write_addr] <= bus.mst_wdata;
                        bus.mst_rdata <= 8'hEE;
                    end else begin
                        bus.mst_rdata <= regs[bus.mst_read_addr];
                    end
                end else begin
                    pend  <= 1'b1;
                    pwr   <= bus.mst_start_write;
                    paddr <= bus.mst_start_write ? bus.mst_write_addr : bus.mst_read_addr;
                    pwd   <= bus.mst_wdata;
                    cnt   <= lat - 1;
                end
            end else if (pend) begin
                if (cnt == 0) begin
                    bus.mst_done <= 1'b1;
                    pend <= 1'b0;
                    if (pwr) begin
                        regs[paddr] <= pwd;
                        bus.mst_rdata <= 8'hEE;
                    end else begin
                        bus.mst_rdata <= regs[paddr];
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant, a start or a response.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.req_ready != 2'b00) begin
                if (grant_q.size() == 0) begin
                    chk("unexpected_req_ready", 32'(bus.req_ready), 32'd0);
                end else begin
                    e = grant_q.pop_front();
                    chk("req_ready", 32'(bus.req_ready), 32'(oh(e.r)));
                end
            end
            if (bus.mst_start_write || bus.mst_start_read) begin
                start_cyc = cyc;
                if (cmd_q.size() == 0) begin
                    chk("unexpected_start", 32'({bus.mst_start_write, bus.mst_start_read}), 32'd0);
                end else begin
                    e = cmd_q.pop_front();
                    chk("start_kind", 32'({bus.mst_start_write, bus.mst_start_read}),
                        e.wr ? 32'd2 : 32'd1);
                    chk("mst_write_addr", 32'(bus.mst_write_addr), 32'(e.addr));
                    chk("mst_read_addr", 32'(bus.mst_read_addr), 32'(e.addr));
                    if (e.wr) chk("mst_wdata", 32'(bus.mst_wdata), 32'(e.wdata));
                end
            end
            if (bus.rsp_valid != 2'b00) begin
                last_lat = cyc - start_cyc;
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh(e.r)));
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic txn(input int r, input bit wr, input logic [1:0] a, input logic [7:0] d);
        int k;
        bus.req_write[r]         = wr;
        bus.req_addr[r*2 +: 2]   = a;
        bus.req_wdata[r*8 +: 8]  = d;
        bus.req_valid[r]         = 1'b1;
        k = 0;
        while (!bus.req_ready[r] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("ready_within_bound", 32'(k < 200), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
        k = 0;
        while (!bus.rsp_valid[r] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_within_bound", 32'(k < 200), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_starts"}, 32'({bus.mst_start_write, bus.mst_start_read}), 32'd0);
        chk({tag, "_mst_write_addr"}, 32'(bus.mst_write_addr), 32'd0);
        chk({tag, "_mst_read_addr"}, 32'(bus.mst_read_addr), 32'd0);
        chk({tag, "_mst_wdata"}, 32'(bus.mst_wdata), 32'd0);
    endtask

    initial begin
        int k;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_write = 2'b00;
        bus.req_addr  = 4'h0;
        bus.req_wdata = 16'h0000;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");

        // Contention from reset: grants must alternate 0,1,0,1.
        expect_txn(0, 1'b1, 2'd0, 8'h11, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 2'd3, 8'h22, 8'h00, 1'b0);
        expect_txn(0, 1'b0, 2'd3, 8'h00, 8'h22, 1'b0);
        expect_txn(1, 1'b0, 2'd0, 8'h00, 8'h11, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        fork
            begin txn(0, 1'b1, 2'd0, 8'h11); txn(0, 1'b0, 2'd3, 8'h00); end
            begin txn(1, 1'b1, 2'd3, 8'h22); txn(1, 1'b0, 2'd0, 8'h00); end
        join

        // Single write then read by requester 0; zero-latency master.
        expect_txn(0, 1'b1, 2'd2, 8'hA5, 8'h00, 1'b0);
        txn(0, 1'b1, 2'd2, 8'hA5);
        expect_txn(0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
        txn(0, 1'b0, 2'd2, 8'h00);
        chk("start_to_rsp_cycles", 32'(last_lat), 32'd2);

        // Requester 1 write returns rdata 0, read returns the written value.
        expect_txn(1, 1'b1, 2'd1, 8'h3C, 8'h00, 1'b0);
        txn(1, 1'b1, 2'd1, 8'h3C);
        expect_txn(1, 1'b0, 2'd1, 8'h00, 8'h3C, 1'b0);
        txn(1, 1'b0, 2'd1, 8'h00);

        // Requester 1 raises and withdraws while requester 0 is waiting on the master.
        lat = 6;
        expect_txn(0, 1'b0, 2'd2, 8'h00, 8'hA5, 1'b0);
        fork
            txn(0, 1'b0, 2'd2, 8'h00);
            begin
                repeat (4) @(negedge clk);
                @(posedge clk);
                #1;
                bus.req_write[1] = 1'b0;
                bus.req_addr[3:2] = 2'd3;
                bus.req_valid[1] = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                bus.req_valid[1] = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        chk("withdraw_no_grant", 32'(grant_q.size()), 32'd0);
        chk("withdraw_no_rsp", 32'(rsp_q.size()), 32'd0);

        // Reset while waiting: outputs clear at once, pointer returns to 0.
        lat = 20;
        expect_txn(0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0);
        bus.req_write[0] = 1'b0;
        bus.req_addr[1:0] = 2'd1;
        bus.req_valid[0] = 1'b1;
        k = 0;
        while (!bus.req_ready[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reset_test_ready_within_bound", 32'(k < 200), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_in_wait", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        expect_txn(0, 1'b0, 2'd1, 8'h00, 8'h00, 1'b0);
        expect_txn(1, 1'b1, 2'd2, 8'h5A, 8'h00, 1'b0);
        fork
            txn(0, 1'b0, 2'd1, 8'h00);
            txn(1, 1'b1, 2'd2, 8'h5A);
        join

`ifdef AXI4LITE_ARB_TIMEOUT_EN
        // Master never answers: watchdog response after 16 WAIT cycles.
        stall = 1'b1;
        expect_txn(0, 1'b0, 2'd2, 8'h00, 8'h00, 1'b1);
        txn(0, 1'b0, 2'd2, 8'h00);
        chk("timeout_start_to_rsp_cycles", 32'(last_lat), 32'd17);
        stall = 1'b0;
        expect_txn(1, 1'b0, 2'd2, 8'h00, 8'h5A, 1'b0);
        txn(1, 1'b0, 2'd2, 8'h00);
`endif

        repeat (5) @(negedge clk);
        chk("grant_q_drained", 32'(grant_q.size()), 32'd0);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_req_arbiter.md
Name: axi4lite_req_arbiter

Overview:
- Shares the single AXI4-Lite master's user-side command port (start_write/start_read, addresses, write data, read data, done) between NREQ independent requesters.
- Arbitration is round-robin. The block latches the winner's command, issues a one-cycle start pulse, waits for the master's done, then returns read data or a write acknowledgment to that requester only.
- Sits between system requesters and the master; the master/slave pair is unchanged.

Parameters:
- NREQ, 2, number of requesters (2..8)
- ADDR_W, 2, register address width (matches slave register map)
- DATA_W, 8, data width
- TIMEOUT_CYCLES, 64, watchdog limit in WAIT (used only with optional feature)

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester command valid, held until accepted
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- req_ready  out  NREQ  one-hot accept pulse, one cycle
- rsp_valid  out  NREQ  one-hot completion pulse, one cycle
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid (shared)
- rsp_err  out  1  timeout flag, valid with rsp_valid; always 0 without the feature
- busy  out  1  high in any state other than IDLE
- mst_start_write  out  1  one-cycle start pulse to master
- mst_start_read  out  1  one-cycle start pulse to master
- mst_write_addr  out  ADDR_W  write address to master
- mst_read_addr  out  ADDR_W  read address to master
- mst_wdata  out  DATA_W  write data to master
- mst_rdata  in  DATA_W  master read data
- mst_done  in  1  master completion pulse

Behaviour:
- Reset values (asynchronous): all outputs 0; state IDLE; round-robin pointer 0; latched command registers 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, grant the first set bit searching from rr_ptr upward with wrap-around.
  - Pulse req_ready[g] that cycle (registered output, visible in the next cycle).
  - Latch write, addr and wdata for the granted requester.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - Assert exactly one of mst_start_write/mst_start_read.
  - Drive the latched addr on both mst_write_addr and mst_read_addr, and drive mst_wdata.
  - Go to WAIT.
- mst_*addr and mst_wdata hold the latched values from ISSUE through RESP.
- WAIT: on mst_done, capture mst_rdata (reads only; writes capture 0) and go to RESP.
- mst_done is ignored in IDLE and ISSUE.
- RESP (1 cycle):
  - rsp_valid[g] = 1 and rsp_rdata valid.
  - rr_ptr <= g+1, wrapping at NREQ.
  - Go to IDLE.
- Requester-visible latency: req_ready one cycle after grant; minimum grant-to-rsp_valid is 3 cycles plus master latency.
- Only one transaction is outstanding at a time; no pipelining.
- The master's done must not be issued within the ISSUE cycle.
- req_valid dropped before acceptance: the request is withdrawn, with no side effects.
- req_valid changes after acceptance are ignored until RESP.
- Simultaneous requests: round-robin guarantees each requester is granted within NREQ transactions.
- rsp_rdata, mst_* and rsp_err hold their last values between transactions.
- Asynchronous reset mid-transaction: abort to IDLE with no response. The master shares rst_n, so both return to idle together.

Optional Feature:
- Macro: AXI4LITE_ARB_TIMEOUT_EN.
- With the macro defined:
  - An 8-bit-or-wider counter clears on entering WAIT and increments each cycle in WAIT.
  - On reaching TIMEOUT_CYCLES without mst_done, go to RESP with rsp_err=1 and rsp_rdata=0.
  - rsp_err=0 on normal completion.
- Without the macro: no counter is instantiated, WAIT waits indefinitely, and rsp_err is tied to 0.

Decomposition:
- Shared package axi4lite_pkg holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - default ADDR_W=2 and DATA_W=8 constants
  - the AXI response codes already used by master/slave (OKAY=2'b00, SLVERR=2'b10)
- One natural sub-module: rr_grant_picker. It is combinational; it takes req_valid and rr_ptr and returns a one-hot grant plus an index.

Test Plan:
- Single read: requester 0 reads addr 2 after the slave was written 8'hA5 → mst_start_read pulses once with addr 2; rsp_valid=2'b01, rsp_rdata=8'hA5, rsp_err=0.
- Single write: requester 1 writes 8'h3C to addr 1, then reads addr 1 → write rsp_valid=2'b10 with rsp_rdata=0; read returns 8'h3C.
- Contention: both req_valid high from reset for 4 transactions → grant order 0,1,0,1; req_ready one-hot; never two mst_start pulses within one transaction.
- Withdraw/hold: requester 1 raises then drops req_valid while requester 0's transaction is in WAIT → no req_ready[1] and no transaction for requester 1.
- Reset mid-operation: assert rst_n=0 during WAIT → all outputs 0 immediately, state IDLE, rr_ptr=0; the next request completes normally.
- Timeout (with AXI4LITE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): force mst_done low → rsp_valid after 16 WAIT cycles with rsp_err=1 and rsp_rdata=0; next transaction rsp_err=0.
